// File: rtl/message_tx_pkg.sv
// Shared types and constants for the UART message transmitter.
// Imported by the top level of the message sender.
package message_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } message_tx_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/message_tx_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// busy rises the cycle after send is sampled and drops after the stop bit.
module uart_tx #(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;

    // Frame shifter: latch the byte on send, then step one bit per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            shift   <= '1;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (!busy) begin
            if (send) begin
                busy    <= 1'b1;
                shift   <= {1'b1, data, 1'b0};
                clk_cnt <= '0;
                bit_cnt <= '0;
            end
        end else if (clk_cnt == CW'(CLOCKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            shift   <= {1'b1, shift[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
                busy <= 1'b0;
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    assign tx = busy ? shift[0] : 1'b1;

endmodule

// File: rtl/message_tx.sv
// Streams a compile-time message (optionally CR/LF terminated) over uart_tx,
// with optional repeat after an idle gap and a frame-safe abort.
module message_tx
    import message_tx_pkg::*;
#(
    parameter int                   CLOCK_RATE  = 100_000_000,
    parameter int                   BAUD_RATE   = 115_200,
    parameter int                   MSG_LEN     = 13,
    parameter logic [MSG_LEN*8-1:0] MESSAGE     = "Hello, World!",
    parameter bit                   APPEND_CRLF = 1'b1,
    parameter int                   GAP_CYCLES  = 1000,
    localparam int                  N           = MSG_LEN + (APPEND_CRLF ? 2 : 0),
    localparam int                  IW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    input  logic          repeat_en,
    input  logic          abort,
    output logic          tx,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] char_index
);

    localparam int CPB = CLOCK_RATE / BAUD_RATE;
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    message_tx_state_t state;
    message_tx_state_t state_next;
    logic [IW-1:0]     idx_next;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_next;
    logic              send;
    logic              send_next;
    logic              done_next;
    logic              uart_busy;
    logic [7:0]        data;

    // Character select: message bytes first-char-MSB, then optional CR, LF.
    always_comb begin
        data = 8'h00;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (char_index == IW'(i)) begin
                data = MESSAGE[(MSG_LEN-1-i)*8 +: 8];
            end
        end
        if (APPEND_CRLF) begin
            if (char_index == IW'(N - 2)) data = ASCII_CR;
            if (char_index == IW'(N - 1)) data = ASCII_LF;
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_next = state;
        idx_next   = char_index;
        gap_next   = gap_cnt;
        send_next  = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (trigger && !abort) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                end
            end
            ST_LOAD: begin
                send_next  = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!uart_busy) begin
                    if (abort) begin
                        state_next = ST_IDLE;
                    end else if (char_index == IW'(N - 1)) begin
                        done_next = 1'b1;
                        if (repeat_en) begin
                            state_next = ST_GAP;
                            gap_next   = GW'(GAP_CYCLES - 1);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        idx_next   = char_index + 1'b1;
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt == '0) begin
                    idx_next   = '0;
                    state_next = ST_LOAD;
                end else begin
                    gap_next = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            char_index <= '0;
            gap_cnt    <= '0;
            send       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            char_index <= idx_next;
            gap_cnt    <= gap_next;
            send       <= send_next;
            done       <= done_next;
        end
    end

    assign busy = (state != ST_IDLE);

    uart_tx #(
        .CLOCKS_PER_BIT(CPB)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .data (data),
        .busy (uart_busy),
        .tx   (tx)
    );

endmodule

// File: tb/tb_message_tx.sv
// Randomised scoreboard bench for message_tx: UART receiver monitors pop
// expected bytes pushed by the stimulus process from a string-level model.
module tb_message_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig_a = 1'b0;
    logic       rep_a = 1'b0;
    logic       abort_a = 1'b0;
    logic       trig_b = 1'b0;
    logic       rep_b = 1'b0;
    logic       abort_b = 1'b0;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;
    logic [2:0] idx_a;
    logic [0:0] idx_b;

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    logic [7:0] ref_a[$];
    logic [7:0] ref_b[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         starts_a[$];

    message_tx #(
        .CLOCK_RATE(1000), .BAUD_RATE(100), .MSG_LEN(2),
        .MESSAGE("Hi"), .APPEND_CRLF(1'b1), .GAP_CYCLES(50)
    ) dut_a (
        .clk(clk), .rst(rst), .trigger(trig_a), .repeat_en(rep_a),
        .abort(abort_a), .tx(tx_a), .busy(busy_a), .done(done_a),
        .char_index(idx_a)
    );

    message_tx #(
        .CLOCK_RATE(1000), .BAUD_RATE(100), .MSG_LEN(1),
        .MESSAGE("A"), .APPEND_CRLF(1'b0), .GAP_CYCLES(50)
    ) dut_b (
        .clk(clk), .rst(rst), .trigger(trig_b), .repeat_en(rep_b),
        .abort(abort_b), .tx(tx_b), .busy(busy_b), .done(done_b),
        .char_index(idx_b)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic logic line(input int ch);
        return (ch == 0) ? tx_a : tx_b;
    endfunction

    // Reference message: text bytes in order, then CR LF if enabled.
    function automatic void build_ref(input string s, input bit crlf,
                                      output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        if (crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endfunction

    task automatic push_a(input int count);
        for (int i = 0; i < count; i++) exp_a.push_back(ref_a[i % ref_a.size()]);
    endtask

    // UART receiver: samples mid-bit, drops frames interrupted by reset.
    task automatic rx_loop(input int ch);
        logic [9:0] fr;
        bit         hit;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (line(ch) === 1'b0 && rst === 1'b0) begin
                if (ch == 0) starts_a.push_back(cyc);
                hit = 1'b0;
                fr  = '0;
                for (int k = 1; k <= 95; k++) begin
                    @(negedge clk);
                    if (rst) hit = 1'b1;
                    if (k % 10 == 5) fr[(k-5)/10] = line(ch);
                end
                if (!hit) begin
                    check($sformatf("rx%0d_framing", ch), {fr[9], fr[0]}, 2'b10);
                    if ((ch == 0 ? exp_a.size() : exp_b.size()) == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL rx%0d_unexpected: got byte %02h, required none",
                                 ch, fr[8:1]);
                    end else begin
                        e = (ch == 0) ? exp_a.pop_front() : exp_b.pop_front();
                        check($sformatf("rx%0d_byte", ch), fr[8:1], e);
                    end
                end
            end
        end
    endtask

    // done monitor: count pulses; busy must already be low unless repeating.
    task automatic done_mon();
        forever begin
            @(negedge clk);
            if (done_a === 1'b1) begin
                done_cnt_a++;
                check("done_a_busy", busy_a, rep_a ? 1 : 0);
            end
            if (done_b === 1'b1) begin
                done_cnt_b++;
                check("done_b_busy", busy_b, 0);
            end
        end
    endtask

    task automatic cyc_cnt();
        forever begin
            @(posedge clk);
            cyc++;
        end
    endtask

    task automatic wait_busy(input int ch, input logic lvl,
                             input int budget, input string name);
        int n = 0;
        while (((ch == 0) ? busy_a : busy_b) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (((ch == 0) ? busy_a : busy_b) !== lvl) begin
            tests++;
            errors++;
            $display("FAIL %s: busy not %0b within %0d cycles", name, lvl, budget);
        end
    endtask

    task automatic wait_starts(input int count, input int budget,
                               input string name);
        int n = 0;
        while (starts_a.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (starts_a.size() < count) begin
            tests++;
            errors++;
            $display("FAIL %s: %0d start bits, required %0d", name,
                     starts_a.size(), count);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s, base_d, t0, j, n;
        build_ref("Hi", 1'b1, ref_a);
        build_ref("A", 1'b0, ref_b);
        fork
            rx_loop(0);
            rx_loop(1);
            done_mon();
            cyc_cnt();
        join_none

        // Reset state
        idle(3);
        check("rst_tx_a", tx_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_idx_a", idx_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;
        idle($urandom_range(2, 20));

        // Single "Hi\r\n" message
        base_s = starts_a.size();
        base_d = done_cnt_a;
        push_a(4);
        trig_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        check("t1_busy_rise", busy_a, 1);
        trig_a = 1'b0;
        wait_busy(0, 1'b0, 1000, "t1_idle");
        idle(20);
        check("t1_done_cnt", done_cnt_a - base_d, 1);
        check("t1_idx_end", idx_a, 3);
        check("t1_busy_end", busy_a, 0);
        check("t1_rx_left", exp_a.size(), 0);
        check("t1_starts", starts_a.size() - base_s, 4);
        if (starts_a.size() > base_s)
            check("t1_start_lat", starts_a[base_s] - t0, 3);

        // One-byte message without CRLF
        idle($urandom_range(2, 20));
        exp_b.push_back(ref_b[0]);
        trig_b = 1'b1;
        @(negedge clk);
        trig_b = 1'b0;
        wait_busy(1, 1'b0, 1000, "t2_idle");
        idle(150);
        check("t2_done_cnt", done_cnt_b, 1);
        check("t2_idx_end", idx_b, 0);
        check("t2_rx_left", exp_b.size(), 0);

        // Repeat: two messages separated by the gap
        idle($urandom_range(2, 20));
        base_s = starts_a.size();
        base_d = done_cnt_a;
        rep_a = 1'b1;
        push_a(8);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        n = 0;
        while (done_cnt_a == base_d && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t3_first_done", done_cnt_a - base_d, 1);
        @(negedge clk);
        rep_a = 1'b0;
        wait_busy(0, 1'b0, 2000, "t3_idle");
        idle(20);
        check("t3_done_cnt", done_cnt_a - base_d, 2);
        check("t3_starts", starts_a.size() - base_s, 8);
        check("t3_rx_left", exp_a.size(), 0);
        // Frame 10 bits, then stop-end -> send = gap+2, send -> start = 1
        for (int i = 1; i < 8; i++) begin
            if (starts_a.size() > base_s + i)
                check($sformatf("t3_interval_%0d", i),
                      starts_a[base_s+i] - starts_a[base_s+i-1],
                      (i == 4) ? 10*CPB + 50 + 3 : 10*CPB + 3);
        end

        // Abort mid-frame of a random character
        idle($urandom_range(2, 20));
        j = $urandom_range(0, 2);
        base_s = starts_a.size();
        base_d = done_cnt_a;
        push_a(j + 1);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        wait_starts(base_s + j + 1, 1000, "t4_reach_char");
        idle($urandom_range(5, 80));
        abort_a = 1'b1;
        wait_busy(0, 1'b0, 1000, "t4_idle");
        abort_a = 1'b0;
        idle(300);
        check("t4_done_cnt", done_cnt_a - base_d, 0);
        check("t4_starts", starts_a.size() - base_s, j + 1);
        check("t4_rx_left", exp_a.size(), 0);
        check("t4_busy", busy_a, 0);

        // Reset mid-frame of character 1, then a clean message
        base_s = starts_a.size();
        push_a(4);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        wait_starts(base_s + 2, 1000, "t5_reach_char");
        idle($urandom_range(5, 80));
        rst = 1'b1;
        @(negedge clk);
        check("t5_tx", tx_a, 1);
        check("t5_busy", busy_a, 0);
        check("t5_idx", idx_a, 0);
        check("t5_done", done_a, 0);
        exp_a.delete();
        @(negedge clk);
        rst = 1'b0;
        idle(150);
        base_s = starts_a.size();
        base_d = done_cnt_a;
        push_a(4);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        wait_busy(0, 1'b0, 1000, "t5_idle");
        idle(20);
        check("t5_done_cnt", done_cnt_a - base_d, 1);
        check("t5_starts", starts_a.size() - base_s, 4);
        check("t5_rx_left", exp_a.size(), 0);

        // Trigger held: restart one cycle after busy falls; pulses ignored
        idle($urandom_range(2, 20));
        base_s = starts_a.size();
        base_d = done_cnt_a;
        push_a(8);
        trig_a = 1'b1;
        wait_busy(0, 1'b1, 10, "t6_start");
        wait_busy(0, 1'b0, 1000, "t6_fall");
        @(negedge clk);
        check("t6_restart", busy_a, 1);
        trig_a = 1'b0;
        repeat (3) begin
            idle($urandom_range(10, 60));
            trig_a = 1'b1;
            @(negedge clk);
            trig_a = 1'b0;
        end
        wait_busy(0, 1'b0, 1000, "t6_idle");
        idle(150);
        check("t6_done_cnt", done_cnt_a - base_d, 2);
        check("t6_starts", starts_a.size() - base_s, 8);
        check("t6_rx_left", exp_a.size(), 0);
        check("t6_busy", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
